// File: rtl/fetch_unit.sv
// Instruction fetch front end: generates the fetch PC, requests words from instruction
// memory, buffers them in a prefetch queue, and flushes on branch/jump redirects.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        IW       = 16,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [IW-1:0]     IMEM_DATA,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  output logic [IW-1:0]     INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fpc;
  logic [IW-1:0]     q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, next_count;
  logic              push, pop;

  // A redirect kills both the returning word and any same-cycle pop.
  always_comb begin
    push       = (state == S_WAIT) && IMEM_ACK && !REDIRECT;
    pop        = (count != '0) && INSTR_READY && !REDIRECT;
    next_count = count + CW'(push) - CW'(pop);
  end

  assign INSTR_VALID = (count != '0);
  assign INSTR       = INSTR_VALID ? q_instr[rd_ptr] : '0;
  assign INSTR_PC    = INSTR_VALID ? q_pc[rd_ptr]    : '0;

  always_ff @(posedge CLK) begin
    if (push) begin
      q_instr[wr_ptr] <= IMEM_DATA;
      q_pc[wr_ptr]    <= IMEM_ADDR;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      IMEM_REQ  <= 1'b0;
      IMEM_ADDR <= '0;
      fpc       <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      if (REDIRECT) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= next_count;
      end

      case (state)
        S_IDLE: begin
          if (REDIRECT) begin
            fpc       <= REDIRECT_PC;
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= REDIRECT_PC;
            state     <= S_WAIT;
          end else if (count < FULL) begin
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= fpc;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (IMEM_ACK) begin
            if (REDIRECT) begin
              fpc       <= REDIRECT_PC;
              IMEM_ADDR <= REDIRECT_PC;
            end else begin
              fpc <= IMEM_ADDR + 1'b1;
              // Keep streaming only while the slot for the next word is guaranteed.
              if (next_count < FULL) begin
                IMEM_ADDR <= IMEM_ADDR + 1'b1;
              end else begin
                IMEM_REQ <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end else if (REDIRECT) begin
            fpc   <= REDIRECT_PC;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (REDIRECT) fpc <= REDIRECT_PC;
          if (IMEM_ACK) begin
            IMEM_ADDR <= REDIRECT ? REDIRECT_PC : fpc;
            state     <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected request addresses and delivered PCs are queued
// by the stimulus and consumed by a negedge monitor.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        req, ack, redirect, instr_valid, instr_ready;
  logic [7:0]  addr, redirect_pc, instr_pc;
  logic [15:0] data, instr;
  int          ack_delay = 0;
  int          wcnt = 0;

  logic        rst2 = 1'b1;
  logic        req2, instr_valid2;
  logic [7:0]  addr2, instr_pc2;
  logic [15:0] instr2;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_addr[$], q_pc[$], q_addr2[$], q_pc2[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  assign ack  = req && ((ack_delay == 0) || (wcnt == ack_delay));
  assign data = mem_word(addr);

  always @(posedge clk) begin
    if (RST || !req || ack) wcnt <= 0;
    else                    wcnt <= wcnt + 1;
  end

  fetch_unit #(.ADDR_W(8), .IW(16), .DEPTH(4), .RESET_PC(8'h00)) u_dut (
    .CLK(clk), .RST(RST),
    .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_ACK(ack), .IMEM_DATA(data),
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .INSTR(instr), .INSTR_PC(instr_pc), .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready)
  );

  fetch_unit #(.ADDR_W(8), .IW(16), .DEPTH(4), .RESET_PC(8'hFE)) u_dut2 (
    .CLK(clk), .RST(rst2),
    .IMEM_REQ(req2), .IMEM_ADDR(addr2), .IMEM_ACK(req2), .IMEM_DATA(mem_word(addr2)),
    .REDIRECT(1'b0), .REDIRECT_PC(8'h00),
    .INSTR(instr2), .INSTR_PC(instr_pc2), .INSTR_VALID(instr_valid2), .INSTR_READY(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    q_addr.delete();
    q_pc.delete();
    tick(2);
    chk("rst_req",   32'(req), 32'd0);
    chk("rst_addr",  32'(addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc",    32'(instr_pc), 32'd0);
    RST = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (q_addr.size() + q_pc.size() + q_addr2.size() + q_pc2.size()) > 0; i++)
      tick(1);
    chk(name, 32'(q_addr.size() + q_pc.size() + q_addr2.size() + q_pc2.size()), 32'd0);
  endtask

  // Monitor: consumes expectations whenever a request is accepted or an instruction is taken.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!RST) begin
        if (req && ack && q_addr.size() > 0) begin
          e = q_addr.pop_front();
          chk("req_addr", 32'(addr), 32'(e));
        end
        if (instr_valid && instr_ready && !redirect && q_pc.size() > 0) begin
          e = q_pc.pop_front();
          chk("out_pc", 32'(instr_pc), 32'(e));
          chk("out_instr", 32'(instr), 32'(mem_word(e)));
        end
      end
      if (!rst2) begin
        if (req2 && q_addr2.size() > 0) begin
          e = q_addr2.pop_front();
          chk("req_addr2", 32'(addr2), 32'(e));
        end
        if (instr_valid2 && q_pc2.size() > 0) begin
          e = q_pc2.pop_front();
          chk("out_pc2", 32'(instr_pc2), 32'(e));
          chk("out_instr2", 32'(instr2), 32'(mem_word(e)));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    redirect = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b1;

    // Zero-wait streaming
    ack_delay = 0;
    do_reset();
    for (int i = 0; i < 8; i++) q_addr.push_back(8'(i));
    for (int i = 0; i < 6; i++) q_pc.push_back(8'(i));
    tick(1);
    chk("t1_first_req", 32'(req), 32'd1);
    chk("t1_first_addr", 32'(addr), 32'd0);
    chk("t1_valid_lat", 32'(instr_valid), 32'd0);
    tick(1);
    chk("t1_valid_rise", 32'(instr_valid), 32'd1);
    chk("t1_first_pc", 32'(instr_pc), 32'd0);
    wait_drain("t1_drain");

    // Backpressure fills the queue, then drains in order
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) q_addr.push_back(8'(i));
    for (int i = 0; i < 5; i++) q_pc.push_back(8'(i));
    tick(6);
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_held", 32'(req), 32'd0);
      chk("t2_valid_held", 32'(instr_valid), 32'd1);
      tick(1);
    end
    chk("t2_head_pc", 32'(instr_pc), 32'd0);
    instr_ready = 1'b1;
    wait_drain("t2_drain");

    // Redirect with three queued entries, ack in the same cycle
    instr_ready = 1'b0;
    do_reset();
    q_addr.push_back(8'h00); q_addr.push_back(8'h01); q_addr.push_back(8'h02);
    q_addr.push_back(8'h03); q_addr.push_back(8'h40); q_addr.push_back(8'h41);
    q_pc.push_back(8'h40); q_pc.push_back(8'h41); q_pc.push_back(8'h42);
    tick(4);
    chk("t3_count3_pc", 32'(instr_pc), 32'd0);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    instr_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    chk("t3_redir_addr", 32'(addr), 32'h40);
    wait_drain("t3_drain");

    // Redirect while a slow request is outstanding
    ack_delay = 3;
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) q_addr.push_back(8'(i));
    q_addr.push_back(8'h40); q_addr.push_back(8'h41);
    for (int i = 0; i < 4; i++) q_pc.push_back(8'(i));
    q_pc.push_back(8'h40); q_pc.push_back(8'h41);
    begin
      int n;
      n = 0;
      while (!(req && addr == 8'h05) && n < 100) begin
        tick(1);
        n++;
      end
      chk("t4_reach_addr5", 32'(req && addr == 8'h05), 32'd1);
    end
    redirect = 1'b1;
    redirect_pc = 8'h40;
    tick(1);
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_req", 32'(req), 32'd1);
      chk("t4_hold_addr", 32'(addr), 32'h05);
      tick(1);
    end
    chk("t4_target_addr", 32'(addr), 32'h40);
    wait_drain("t4_drain");

    // Address wrap on the FE-reset instance
    RST = 1'b1;
    ack_delay = 0;
    q_addr2.push_back(8'hFE); q_addr2.push_back(8'hFF);
    q_addr2.push_back(8'h00); q_addr2.push_back(8'h01);
    q_pc2.push_back(8'hFE); q_pc2.push_back(8'hFF);
    q_pc2.push_back(8'h00); q_pc2.push_back(8'h01);
    tick(1);
    chk("t5_rst_req2", 32'(req2), 32'd0);
    rst2 = 1'b0;
    tick(1);
    chk("t5_first_addr2", 32'(addr2), 32'hFE);
    wait_drain("t5_drain");
    rst2 = 1'b1;

    // Asynchronous reset between edges while waiting on memory
    ack_delay = 3;
    instr_ready = 1'b0;
    do_reset();
    q_addr.push_back(8'h00);
    tick(6);
    chk("t6_pre_req", 32'(req), 32'd1);
    chk("t6_pre_valid", 32'(instr_valid), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_async_req", 32'(req), 32'd0);
    chk("t6_async_valid", 32'(instr_valid), 32'd0);
    chk("t6_async_addr", 32'(addr), 32'd0);
    q_addr.delete();
    q_pc.delete();
    ack_delay = 0;
    instr_ready = 1'b1;
    q_addr.push_back(8'h00); q_addr.push_back(8'h01);
    q_pc.push_back(8'h00); q_pc.push_back(8'h01);
    tick(2);
    RST = 1'b0;
    tick(1);
    chk("t6_restart_addr", 32'(addr), 32'd0);
    chk("t6_restart_req", 32'(req), 32'd1);
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end for the 16-bit single-cycle/multi-cycle MIPS-style core.
- Generates the fetch PC, issues requests to instruction memory, and buffers returned words in a small prefetch queue.
- Presents `{instruction, pc}` to the opcode decoder (opcode = INSTR[15:12]).
- Accepts PC redirects from branch/jump resolution (BEQ/BNE taken, JUMP), flushing wrong-path instructions.

Parameters:
- ADDR_W, 8, instruction word-address width; PC wraps modulo 2^ADDR_W.
- IW, 16, instruction width.
- DEPTH, 4, prefetch queue entries; power of 2, at least 2.
- RESET_PC, 0, fetch address after reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IMEM_REQ  out  1  request valid; registered.
- IMEM_ADDR  out  ADDR_W  request word address; registered, stable while IMEM_REQ=1 and not acked.
- IMEM_ACK  in  1  memory accepts the request and returns data this cycle; may be combinational from IMEM_REQ.
- IMEM_DATA  in  IW  instruction word, valid when IMEM_ACK=1.
- REDIRECT  in  1  branch/jump taken; single-cycle pulse.
- REDIRECT_PC  in  ADDR_W  target word address.
- INSTR  out  IW  head-of-queue instruction.
- INSTR_PC  out  ADDR_W  address of INSTR.
- INSTR_VALID  out  1  queue non-empty.
- INSTR_READY  in  1  decoder consumes head when INSTR_VALID & INSTR_READY.

Behaviour:
- Reset (async, while RST=1) forces:
  - IMEM_REQ=0, IMEM_ADDR=0.
  - Queue empty: INSTR_VALID=0, INSTR=0, INSTR_PC=0.
  - fpc=RESET_PC, state IDLE.
  - An outstanding request is abandoned; memory must tolerate this.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data wanted.
  - DRAIN: request outstanding, data to be discarded.
- IDLE:
  - If no REDIRECT and count < DEPTH: next cycle IMEM_REQ=1, IMEM_ADDR=fpc, go to WAIT.
  - First request therefore appears 1 cycle after RST deasserts.
- WAIT with IMEM_ACK=1:
  - Push {IMEM_DATA, IMEM_ADDR}; fpc <= IMEM_ADDR+1 (wraps).
  - If the post-push/pop count < DEPTH: stay WAIT with IMEM_ADDR=IMEM_ADDR+1, giving back-to-back fetch at 1 word/cycle.
  - Otherwise IMEM_REQ=0 next cycle and go to IDLE.
- WAIT with IMEM_ACK=0: hold IMEM_REQ and IMEM_ADDR.
- Slot reservation: a request is only issued when a queue slot is free, so a push never overflows. Push and pop in the same cycle leave count unchanged.
- Queue outputs:
  - INSTR, INSTR_PC and INSTR_VALID reflect the head entry.
  - A pushed word is visible on INSTR the cycle after IMEM_ACK, i.e. minimum latency REQ→INSTR_VALID is 1 cycle with zero-wait memory.
- REDIRECT=1 (highest priority, any state):
  - Queue flushed; INSTR_VALID=0 next cycle. A pop in the same cycle is ignored.
  - fpc <= REDIRECT_PC.
  - WAIT, no ACK this cycle: go to DRAIN, keep IMEM_REQ/IMEM_ADDR until ACK, discard data, then issue REDIRECT_PC the cycle after the ACK.
  - WAIT, ACK this cycle: data dropped, next cycle IMEM_REQ=1, IMEM_ADDR=REDIRECT_PC, state WAIT.
  - IDLE: next cycle IMEM_REQ=1, IMEM_ADDR=REDIRECT_PC, state WAIT.
  - DRAIN: update target only; the last REDIRECT_PC wins.
- Wrong-path words never appear on INSTR.
- Wrap-around: address FF+1 = 00 for ADDR_W=8. Queue pointers wrap modulo DEPTH.
- REDIRECT during RST is ignored.

Test Plan:
1. RESET_PC=0, IMEM_ACK tied to IMEM_REQ, INSTR_READY=1 → IMEM_ADDR 0,1,2,… on consecutive cycles from 1 cycle after reset release. INSTR_VALID rises one cycle after the first ACK with INSTR_PC=0, then 1,2,3 back-to-back.
2. INSTR_READY=0 from reset → exactly 4 ACKs (addr 0–3), then IMEM_REQ=0 and held. Raise INSTR_READY → INSTR_PC 0,1,2,3 drain in order and fetch resumes at addr 4.
3. REDIRECT with REDIRECT_PC=0x40 while the queue holds 3 entries → INSTR_VALID=0 the next cycle, then IMEM_ADDR=0x40. First delivered INSTR_PC=0x40, then 0x41.
4. Memory ACK delayed 3 cycles; REDIRECT to 0x40 while addr 5 is outstanding → IMEM_ADDR stays 5 until ACK. Data from addr 5 is never on INSTR; the next request is 0x40.
5. RESET_PC=0xFE, ADDR_W=8 → fetch addresses FE, FF, 00, 01, with INSTR_PC matching.
6. Assert RST asynchronously mid-WAIT (between edges) → IMEM_REQ=0 and INSTR_VALID=0 immediately. After release, the first IMEM_ADDR equals RESET_PC.
